// File: rtl/top_counter_pkg.sv
// -----------------------------------------------------------------------------
// top_counter_pkg
// Shared constants for the seconds counter: divider width, output counter
// range and the board clock rate used as the 1 Hz divisor.
// No ports (package).
// -----------------------------------------------------------------------------
package top_counter_pkg;

   // Width of the programmable divisor and of the divider counter.
   localparam int DIV_W   = 32;

   // Terminal value of the output counter; it wraps to 0 after this.
   localparam int CNT_MAX = 59;

   // Width of the output count; 2**OUT_W must exceed CNT_MAX.
   localparam int OUT_W   = 6;

   // Board clock frequency; used as num for one tick per second.
   localparam int CLK_HZ  = 50_000_000;

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Programmable divider producing a one-cycle tick every num clock cycles.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset, clears the divider counter
//   num  - clock cycles per tick, unsigned, sampled every cycle
//   tick - combinational enable, high on the last cycle of each period
// -----------------------------------------------------------------------------
module tick_gen
   import top_counter_pkg::*;
#(
   parameter int DIV_W_P = DIV_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DIV_W_P-1:0] num,
   output logic               tick
);

   logic [DIV_W_P-1:0] div_cnt;

   // A >= compare rather than == means lowering num below the current
   // count ends the period on the next cycle instead of running the counter
   // all the way round. num of 0 or 1 is forced to tick every cycle because
   // num-1 would underflow for 0.
   always_comb begin
      tick = 1'b0;
      if (num <= DIV_W_P'(1)) begin
         tick = 1'b1;
      end else if (div_cnt >= (num - DIV_W_P'(1))) begin
         tick = 1'b1;
      end
   end

   // Divider counter: restarts from zero on the tick cycle, otherwise counts up.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W_P'(1);
      end
   end

endmodule

// File: rtl/top_counter.sv
// -----------------------------------------------------------------------------
// top_counter
// Seconds counter: tick_gen divides clk by num and each tick advances a
// modulo-(CNT_MAX+1) counter that drives out.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset, clears divider and count
//   num - clock cycles per count step (CLK_HZ gives one step per second)
//   out - registered count, 0..CNT_MAX
// -----------------------------------------------------------------------------
module top_counter
   import top_counter_pkg::*;
#(
   parameter int DIV_W_P   = DIV_W,
   parameter int CNT_MAX_P = CNT_MAX,
   parameter int OUT_W_P   = OUT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DIV_W_P-1:0] num,
   output logic [OUT_W_P-1:0] out
);

   logic tick;

   // Divider that turns the board clock into one-cycle count enables.
   tick_gen #(
      .DIV_W_P (DIV_W_P)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .num  (num),
      .tick (tick)
   );

   // Output counter: steps once per tick and wraps after CNT_MAX, so out
   // never leaves 0..CNT_MAX. Reset wins over a coincident tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         out <= '0;
      end else if (tick) begin
         if (out == OUT_W_P'(CNT_MAX_P)) begin
            out <= '0;
         end else begin
            out <= out + OUT_W_P'(1);
         end
      end
   end

endmodule

// File: tb/tb_top_counter.sv
// -----------------------------------------------------------------------------
// tb_top_counter
// Self-checking bench for top_counter. Each scenario pushes (edge, value)
// expectations into a scoreboard queue computed from the divide ratio, then
// clocks the design and pops/compares whenever the edge number matches.
// -----------------------------------------------------------------------------
module tb_top_counter;
   import top_counter_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic [DIV_W-1:0] num;
   logic [OUT_W-1:0] out;

   typedef struct {
      int               edge_no;
      logic [OUT_W-1:0] val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   top_counter dut (
      .clk (clk),
      .rst (rst),
      .num (num),
      .out (out)
   );

   // 50 MHz clock.
   always #10 clk = ~clk;

   // Reset held for two edges, then the first three steps at num=5.
   task automatic test_reset();
      rst = 1'b1;
      num = 5;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_out cycle %0d: got %0d expected 0", i, out);
         end
      end
      rst = 1'b0;
      for (int e = 1; e <= 15; e++) sb.push_back('{e, OUT_W'(e / 5)});
      for (int e = 1; e <= 15; e++) begin
         @(posedge clk); #1;
         if (sb.size() > 0 && sb[0].edge_no == e) begin
            exp_t x = sb.pop_front();
            checks++;
            if (out !== x.val) begin
               errors++;
               $display("[TB] FAIL reset_step edge %0d: got %0d expected %0d", e, out, x.val);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL reset_leftover: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   // num=3 for a full wrap: 59 at edge 177, 0 at edge 180.
   task automatic test_wrap();
      rst = 1'b1;
      num = 3;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int e = 1; e <= 180; e++) sb.push_back('{e, OUT_W'((e / 3) % (CNT_MAX + 1))});
      for (int e = 1; e <= 180; e++) begin
         @(posedge clk); #1;
         if (sb.size() > 0 && sb[0].edge_no == e) begin
            exp_t x = sb.pop_front();
            checks++;
            if (out !== x.val) begin
               errors++;
               $display("[TB] FAIL wrap edge %0d: got %0d expected %0d", e, out, x.val);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL wrap_leftover: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   // num=1 then num=0 (switched on the fly): one step every clock.
   task automatic test_back_to_back();
      rst = 1'b1;
      num = 1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int e = 1; e <= 122; e++) sb.push_back('{e, OUT_W'(e % (CNT_MAX + 1))});
      for (int e = 1; e <= 122; e++) begin
         @(posedge clk); #1;
         if (sb.size() > 0 && sb[0].edge_no == e) begin
            exp_t x = sb.pop_front();
            checks++;
            if (out !== x.val) begin
               errors++;
               $display("[TB] FAIL every_clock num=%0d edge %0d: got %0d expected %0d",
                        num, e, out, x.val);
            end
         end
         if (e == 61) num = 0;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL every_clock_leftover: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   // num=100 lowered to 10 when the divider sits at 50: step on the next
   // edge, then every 10 edges.
   task automatic test_lower_num();
      rst = 1'b1;
      num = 100;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int e = 1; e <= 91; e++) begin
         if (e <= 50) sb.push_back('{e, OUT_W'(0)});
         else         sb.push_back('{e, OUT_W'(1 + (e - 51) / 10)});
      end
      for (int e = 1; e <= 91; e++) begin
         @(posedge clk); #1;
         if (sb.size() > 0 && sb[0].edge_no == e) begin
            exp_t x = sb.pop_front();
            checks++;
            if (out !== x.val) begin
               errors++;
               $display("[TB] FAIL lower_num edge %0d: got %0d expected %0d", e, out, x.val);
            end
         end
         if (e == 50) begin
            checks++;
            if (dut.u_tick_gen.div_cnt !== DIV_W'(50)) begin
               errors++;
               $display("[TB] FAIL lower_num_div: got %0d expected 50", dut.u_tick_gen.div_cnt);
            end
            num = 10;
            #1;
            checks++;
            if (dut.tick !== 1'b1) begin
               errors++;
               $display("[TB] FAIL lower_num_tick: got %b expected 1", dut.tick);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL lower_num_leftover: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   // num=4: reset pulse at out=37, div_cnt=2 aborts the count; the next
   // step comes 4 edges after release.
   task automatic test_mid_reset();
      rst = 1'b1;
      num = 4;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int e = 1; e <= 163; e++) begin
         if (e <= 150)      sb.push_back('{e, OUT_W'(e / 4)});
         else if (e == 151) sb.push_back('{e, OUT_W'(0)});
         else               sb.push_back('{e, OUT_W'((e - 151) / 4)});
      end
      for (int e = 1; e <= 163; e++) begin
         @(posedge clk); #1;
         if (sb.size() > 0 && sb[0].edge_no == e) begin
            exp_t x = sb.pop_front();
            checks++;
            if (out !== x.val) begin
               errors++;
               $display("[TB] FAIL mid_reset edge %0d: got %0d expected %0d", e, out, x.val);
            end
         end
         if (e == 150) begin
            checks++;
            if (out !== OUT_W'(37) || dut.u_tick_gen.div_cnt !== DIV_W'(2)) begin
               errors++;
               $display("[TB] FAIL mid_reset_pre: got out=%0d div=%0d expected out=37 div=2",
                        out, dut.u_tick_gen.div_cnt);
            end
            rst = 1'b1;
         end
         if (e == 151) begin
            checks++;
            if (dut.u_tick_gen.div_cnt !== '0) begin
               errors++;
               $display("[TB] FAIL mid_reset_div: got %0d expected 0", dut.u_tick_gen.div_cnt);
            end
            rst = 1'b0;
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL mid_reset_leftover: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Long period (20000 cycles stands in for the one-second divisor):
   // step exactly at each period boundary, not one clock early.
   task automatic test_long_period();
      localparam int N = 20000;
      rst = 1'b1;
      num = N;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.push_back('{1,         OUT_W'(0)});
      sb.push_back('{N - 1,     OUT_W'(0)});
      sb.push_back('{N,         OUT_W'(1)});
      sb.push_back('{2 * N - 1, OUT_W'(1)});
      sb.push_back('{2 * N,     OUT_W'(2)});
      for (int e = 1; e <= 2 * N; e++) begin
         @(posedge clk); #1;
         if (sb.size() > 0 && sb[0].edge_no == e) begin
            exp_t x = sb.pop_front();
            checks++;
            if (out !== x.val) begin
               errors++;
               $display("[TB] FAIL long_period edge %0d: got %0d expected %0d", e, out, x.val);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL long_period_leftover: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      rst = 1'b1;
      num = 5;
      $display("[TB] starting top_counter bench");
      test_reset();
      test_wrap();
      test_back_to_back();
      test_lower_num();
      test_mid_reset();
      test_long_period();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/top_counter.md
Name: top_counter

Overview:
- Single-clock seconds counter: a programmable tick generator divides `clk` by `num` and produces one-cycle enable pulses.
- A modulo-60 counter advances once per pulse and drives the 6-bit `out`.
- With `num` = 50,000,000 at 50 MHz, `out` counts seconds 0..59 and wraps.
- Sits between the board clock and the display/decoder logic.

Parameters:
- DIV_W, 32, width of the `num` input and of the internal divider counter.
- CNT_MAX, 59, terminal value of the output counter; it wraps to 0 after this value.
- OUT_W, 6, width of `out`; must satisfy 2^OUT_W > CNT_MAX.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- num  input  DIV_W  clock cycles per tick; sampled every cycle and treated as unsigned.
- out  output  OUT_W  current count, 0..CNT_MAX; registered.

Behaviour:
- Reset:
  - `rst`=1 at a rising edge clears the divider counter `div_cnt` to 0, `tick` to 0 and `out` to 0.
  - Reset has priority over every other event.
  - Reset asserted mid-count aborts the count immediately, with no partial tick.
- Divider:
  - `tick` = 1 when `div_cnt` >= `num`-1; otherwise 0. `tick` is combinational from `div_cnt` and `num`.
  - On each non-reset rising edge: if `tick`, then `div_cnt` <= 0; else `div_cnt` <= `div_cnt`+1.
  - The >= compare covers `num` being lowered below the current count: the next cycle ticks and the counter wraps; no run-away through 2^32.
  - `num` = 0 or 1: `tick` is asserted every cycle, so `out` increments each clock.
- Output counter, on each non-reset rising edge with `tick`=1:
  - `out` == CNT_MAX -> `out` <= 0.
  - otherwise `out` <= `out`+1.
  - With `tick`=0, `out` holds.
- Latency:
  - After the first non-reset edge, the first increment (`out` 0->1) lands on the `num`-th rising edge with `rst`=0.
  - Each subsequent increment follows exactly `num` cycles later.
- `out` never exceeds CNT_MAX. A full wrap takes (CNT_MAX+1) x `num` cycles.
- There are no combinational paths from inputs to `out`.

Decomposition:
- Shared package `top_counter_pkg` holds:
  - DIV_W, CNT_MAX and OUT_W defaults.
  - CLK_HZ = 50_000_000, used as the default `num` for 1 Hz operation.
- Sub-module `tick_gen` contains the divider counter and the tick compare.
  - Ports: `clk`, `rst`, `num`, `tick`.
- The top level contains `tick_gen` plus the modulo-(CNT_MAX+1) counter.

Test Plan:
1. `num`=5; hold `rst`=1 for 2 cycles, then release.
   - `out`=0 during reset.
   - `out`=1 at the 5th edge after release, 2 at the 10th, 3 at the 15th.
2. `num`=3; run 180 cycles after reset.
   - `out` reaches 59 at cycle 177.
   - `out` = 0 at cycle 180; wrap checked, never 60.
3. `num`=1, then `num`=0.
   - `out` increments every clock: 0,1,2,...,59,0.
4. `num`=100; at `div_cnt`=50 switch `num` to 10.
   - `tick` on the next cycle and `out` +1.
   - Thereafter `out` increments every 10 cycles.
5. `num`=4; assert `rst` for one cycle while `out`=37 and `div_cnt`=2.
   - `out`=0 and `div_cnt`=0 on that edge.
   - Next increment occurs 4 cycles after release.
6. `num`=50,000,000, 50 MHz clock, run 2 s of simulated time.
   - `out` steps once every 1 s.
   - Check `out`=1 at 1.0 s and `out`=2 at 2.0 s, each within one clock.
